gcd_job_arbiter: RTL and testbench
==================================

Name: gcd_job_arbiter

Overview:
- Shares one GCD engine (datapath plus its controller) between NREQ independent requesters.
- Picks one pending job with round-robin priority and sequences the engine for it: clear, load A, load B, run, collect the result.
- Returns the result to the requester with its ID.
- Resolves zero-operand jobs directly, without using the engine (a subtractive engine never terminates on a zero operand).
- Sits between client blocks and the GCD engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand/result width in bits.
- TIMEOUT, 1024, maximum RUN cycles before the job is aborted with an error.
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job pending; held until accepted.
- req_a  in  NREQ*W  operand A for requester i, bits [i*W +: W].
- req_b  in  NREQ*W  operand B for requester i, bits [i*W +: W].
- req_ready  out  NREQ  one-hot accept pulse, one cycle, to the granted requester.
- rsp_valid  out  1  response available.
- rsp_id  out  IDW  requester index of the response.
- rsp_gcd  out  W  result; 0 when rsp_err=1.
- rsp_err  out  1  job aborted by timeout.
- rsp_ready  in  1  response consumer accepts.
- eng_clr  out  1  one-cycle clear to the engine.
- eng_start  out  1  engine start pulse; A is presented on eng_din in the same cycle.
- eng_din  out  W  engine data input.
- eng_done  in  1  engine finished (level).
- eng_result  in  W  engine GCD value, valid while eng_done=1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, round-robin pointer last=NREQ-1 (requester 0 first), all outputs 0.
- Reset asserted mid-job drops the job: no response is produced and the engine is not touched until the next job's CLR.
- FSM states: IDLE, CLR, LOAD_A, LOAD_B, RUN, RESP.
- IDLE, when any req_valid bit is set:
  - Grant the first set bit searching last+1 … last+NREQ, modulo NREQ.
  - Pulse req_ready[i] and latch a, b, id. Update last=i only on accept.
  - If a==0 or b==0: set gcd=a|b (0 if both are 0), err=0, go to RESP. Otherwise go to CLR.
- CLR: eng_clr=1 for one cycle, then LOAD_A.
- LOAD_A: eng_start=1, eng_din=a, then LOAD_B.
- LOAD_B: eng_din=b, timer=0, then RUN.
- eng_din is 0 in every state other than LOAD_A and LOAD_B.
- RUN:
  - eng_done=1: latch eng_result, err=0, go to RESP.
  - Else if timer==TIMEOUT-1: gcd=0, err=1, go to RESP.
  - Else timer+1. The timer is $clog2(TIMEOUT)+1 bits wide and never wraps.
- RESP:
  - rsp_valid=1; rsp_id, rsp_gcd and rsp_err are held stable until rsp_ready=1.
  - On the handshake cycle, go to IDLE. No new accept happens in that cycle; the earliest next accept is the following cycle.
- Latency, with accept in cycle T:
  - Zero bypass: rsp_valid from T+1.
  - Normal job: eng_start at T+2, RUN from T+4; rsp_valid the cycle after eng_done is sampled high.
- req_valid deasserting without an accept is legal and ignored.
- req_ready is never asserted outside IDLE.
- Simultaneous requests: exactly one grant per accept cycle; no requester waits more than NREQ-1 other jobs.
- eng_done seen high during CLR, LOAD_A or LOAD_B is ignored (stale from the previous job).

Decomposition:
- Package gcd_arb_pkg: state enum (3-bit encoding IDLE=0 … RESP=5), default W, TIMEOUT.
- Sub-module rr_arbiter: combinational round-robin pick (req vector, last pointer → one-hot grant, index, any).
- gcd_job_arbiter holds the FSM, the operand/ID registers, the timer and the response register.

Test Plan:
- Single requester 1, a=48, b=18, behavioural engine → eng_start at T+2 with eng_din=48, eng_din=18 at T+3; response id=1, gcd=6, err=0.
- Requester 2, a=0, b=35 → no eng_clr/eng_start; rsp_valid at T+1 with gcd=35. Then a=0, b=0 → gcd=0.
- All four requesters valid from reset → service order 0,1,2,3. Re-raise 0 and 3 → order 0,3. Pointer wraps correctly.
- rsp_ready held low 5 cycles during RESP → rsp fields stable, req_ready stays 0; after the handshake, the next accept happens one cycle later.
- Engine model never asserts eng_done, TIMEOUT=16 → rsp_err=1, gcd=0 exactly 16 RUN cycles after LOAD_B; the next job runs normally (42, 56 → 14).
- rst pulsed during RUN → busy=0 and all outputs 0 the next cycle, no response emitted; the following job from requester 0 completes correctly.

Source files
------------

// File: rtl/gcd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_arb_pkg
//  Description : Shared types and defaults for the GCD job arbiter:
//                FSM state encoding and default widths/limits.
//  Revision    : 1.0  initial release
// ============================================================================
package gcd_arb_pkg;

    // 3-bit state encoding, IDLE=0 ... RESP=5
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_RUN    = 3'd4,
        ST_RESP   = 3'd5
    } arb_state_e;

    localparam int DEFAULT_NREQ    = 4;
    localparam int DEFAULT_W       = 16;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage : gcd_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Searches last+1 .. last+NREQ
//                (mod NREQ) and returns the first requesting index.
//  Ports       : req_i   - request vector
//                last_i  - index granted most recently
//                grant_o - one-hot grant (all zero when nothing requests)
//                idx_o   - granted index
//                any_o   - at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int          cand;
        logic [IDW-1:0] cand_idx;
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // k=1 is the requester right after the last grant; k=NREQ is the
        // last grantee itself, so it only wins when nobody else requests.
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last_i) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o             = 1'b1;
                idx_o             = cand_idx;
                grant_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/gcd_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_job_arbiter
//  Description : Shares one GCD engine between NREQ requesters. Grants jobs
//                round-robin, sequences the engine (clear, load A, load B,
//                run), bounds the run time, and returns the result with the
//                requester ID. Jobs with a zero operand bypass the engine.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_valid/a/b     - per-requester job request and operands
//                req_ready         - one-cycle one-hot accept pulse
//                rsp_valid/id/gcd/err, rsp_ready - response handshake
//                eng_clr/start/din - engine control and data
//                eng_done/result   - engine completion and result
//                busy              - arbiter not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module gcd_job_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NREQ    = DEFAULT_NREQ,
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_gcd,
    output logic              rsp_err,
    input  logic              rsp_ready,
    output logic              eng_clr,
    output logic              eng_start,
    output logic [W-1:0]      eng_din,
    input  logic              eng_done,
    input  logic [W-1:0]      eng_result,
    output logic              busy
);

    // One extra bit so the timer can reach TIMEOUT-1 for any TIMEOUT.
    localparam int            TW   = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_q,  last_d;
    logic [IDW-1:0]  id_q,    id_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic [W-1:0]    gcd_q,   gcd_d;
    logic            err_q,   err_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic [W-1:0]    w_op_a;
    logic [W-1:0]    w_op_b;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req_i   (req_valid),
        .last_i  (last_q),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    assign w_op_a = req_a[w_idx*W +: W];
    assign w_op_b = req_b[w_idx*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gcd_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        gcd_d     = gcd_q;
        err_d     = err_q;
        timer_d   = timer_q;
        req_ready = '0;
        eng_clr   = 1'b0;
        eng_start = 1'b0;
        eng_din   = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready = w_grant;
                    a_d       = w_op_a;
                    b_d       = w_op_b;
                    id_d      = w_idx;
                    last_d    = w_idx;
                    // A subtractive engine would never finish on a zero
                    // operand; gcd(x,0)=x and gcd(0,0) is reported as 0.
                    if ((w_op_a == '0) || (w_op_b == '0)) begin
                        gcd_d   = w_op_a | w_op_b;
                        err_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR: begin
                eng_clr = 1'b1;
                state_d = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                eng_start = 1'b1;
                eng_din   = a_q;
                state_d   = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                eng_din = b_q;
                timer_d = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // eng_done is only trusted here; a level left over from the
                // previous job is cleared by the engine during CLR.
                if (eng_done) begin
                    gcd_d   = eng_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == TMAX) begin
                    gcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_gcd   = gcd_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : gcd_job_arbiter
`default_nettype wire

// File: tb/tb_gcd_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_job_arbiter
//  Description : Self-checking bench for gcd_job_arbiter with a behavioural
//                GCD engine and a round-robin / Euclid reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gcd_job_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;
    localparam int IDW     = 2;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic [NREQ-1:0]   req_valid  = '0;
    logic [NREQ*W-1:0] req_a      = '0;
    logic [NREQ*W-1:0] req_b      = '0;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_gcd;
    logic              rsp_err;
    logic              rsp_ready  = 1'b1;
    logic              eng_clr;
    logic              eng_start;
    logic [W-1:0]      eng_din;
    logic              eng_done   = 1'b0;
    logic [W-1:0]      eng_result = '0;
    logic              busy;

    always #5 clk = ~clk;

    gcd_job_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_gcd    (rsp_gcd),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .eng_clr    (eng_clr),
        .eng_start  (eng_start),
        .eng_din    (eng_din),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural engine: A latched with start, B the next cycle, result
    // after a random delay; done stays high until the next clear.
    logic       eng_hang = 1'b0;
    logic [1:0] e_phase  = 2'd0;
    logic [W-1:0] e_a = '0, e_b = '0;
    int         e_cnt = 0;

    always @(posedge clk) begin
        if (eng_clr) begin
            eng_done <= 1'b0;
            e_phase  <= 2'd0;
        end else if (eng_start) begin
            e_a     <= eng_din;
            e_phase <= 2'd1;
        end else if (e_phase == 2'd1) begin
            e_b     <= eng_din;
            e_phase <= 2'd2;
            e_cnt   <= $urandom_range(0, 8);
        end else if (e_phase == 2'd2 && !eng_hang) begin
            if (e_cnt == 0) begin
                eng_done   <= 1'b1;
                eng_result <= gcd_ref(e_a, e_b);
                e_phase    <= 2'd3;
            end else begin
                e_cnt <= e_cnt - 1;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ready_bad = 0;
    int m_last = NREQ - 1;

    // per-cycle snapshot taken after this cycle's inputs settle
    int              s_cyc;
    logic [NREQ-1:0] s_req_ready;
    logic            s_busy, s_rsp_valid, s_rsp_err, s_eng_clr, s_eng_start, s_eng_done;
    logic [IDW-1:0]  s_rsp_id;
    logic [W-1:0]    s_rsp_gcd, s_eng_din;

    logic [W-1:0] op_a [NREQ];
    logic [W-1:0] op_b [NREQ];
    int exp_q[$];
    int got_id[$];
    logic [W-1:0] got_g[$];
    logic got_e[$];

    task automatic tick();
        #1;
        s_cyc       = cyc;
        s_req_ready = req_ready;
        s_busy      = busy;
        s_rsp_valid = rsp_valid;
        s_rsp_id    = rsp_id;
        s_rsp_gcd   = rsp_gcd;
        s_rsp_err   = rsp_err;
        s_eng_clr   = eng_clr;
        s_eng_start = eng_start;
        s_eng_din   = eng_din;
        s_eng_done  = eng_done;
        if (s_req_ready != '0 && s_busy) ready_bad++;
        if ($countones(s_req_ready) > 1) ready_bad++;
        @(negedge clk);
        cyc++;
        req_valid = req_valid & ~s_req_ready;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic run_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int t_acc, output int t_start, output int t_done,
                           output int t_rsp, output logic [W-1:0] din_a,
                           output logic [W-1:0] din_b, output int id,
                           output logic [W-1:0] g, output logic e, output int nclr);
        t_acc = -1; t_start = -1; t_done = -1; t_rsp = -1;
        din_a = '0; din_b = '0; id = -1; g = '0; e = 1'b0; nclr = 0;
        rsp_ready = 1'b1;
        set_req(idx, a, b);
        for (int k = 0; k < 300 && t_rsp < 0; k++) begin
            tick();
            if (s_req_ready[idx] && t_acc < 0) t_acc = s_cyc;
            if (s_eng_clr) nclr++;
            if (s_eng_start) begin t_start = s_cyc; din_a = s_eng_din; end
            if (t_start >= 0 && s_cyc == t_start + 1) din_b = s_eng_din;
            if (t_start >= 0 && s_cyc >= t_start + 2 && s_eng_done && t_done < 0) t_done = s_cyc;
            if (s_rsp_valid) begin
                t_rsp = s_cyc; id = int'(s_rsp_id); g = s_rsp_gcd; e = s_rsp_err;
            end
        end
        m_last = idx;
    endtask

    // Expected service order: repeatedly the first pending index after the
    // last grant, modulo NREQ.
    task automatic model_order(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pend;
        int c;
        pend = mask;
        exp_q.delete();
        while (pend != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                c = (m_last + k) % NREQ;
                if (pend[c]) begin
                    exp_q.push_back(c);
                    pend[c] = 1'b0;
                    m_last  = c;
                    break;
                end
            end
        end
    endtask

    task automatic run_batch(input logic [NREQ-1:0] mask, input bit rand_ready);
        got_id.delete(); got_g.delete(); got_e.delete();
        for (int i = 0; i < NREQ; i++)
            if (mask[i]) set_req(i, op_a[i], op_b[i]);
        for (int k = 0; k < 2000 && got_id.size() < $countones(mask); k++) begin
            rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (s_rsp_valid && rsp_ready) begin
                got_id.push_back(int'(s_rsp_id));
                got_g.push_back(s_rsp_gcd);
                got_e.push_back(s_rsp_err);
            end
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0; m_last = NREQ - 1;
        tick();
        checks++;
        if (s_busy !== 1'b0 || s_rsp_valid !== 1'b0 || s_req_ready !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b req_ready=%b expected 0/0/0", s_busy, s_rsp_valid, s_req_ready);
        end
        checks++;
        if (s_rsp_id !== '0 || s_rsp_gcd !== '0 || s_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: id=%0d gcd=%0d err=%b expected 0", s_rsp_id, s_rsp_gcd, s_rsp_err);
        end
        checks++;
        if (s_eng_clr !== 1'b0 || s_eng_start !== 1'b0 || s_eng_din !== '0) begin
            errors++;
            $display("FAIL reset_eng: clr=%b start=%b din=%0d expected 0", s_eng_clr, s_eng_start, s_eng_din);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_single();
        int ta, ts, td, tr, id, nc; logic [W-1:0] da, db, g; logic e;
        run_one(1, 16'd48, 16'd18, ta, ts, td, tr, da, db, id, g, e, nc);
        checks++;
        if (ta < 0 || ts !== ta + 2) begin
            errors++; $display("FAIL single_start: start=%0d accept=%0d expected start=accept+2", ts, ta);
        end
        checks++;
        if (da !== 16'd48 || db !== 16'd18) begin
            errors++; $display("FAIL single_din: a=%0d b=%0d expected 48 18", da, db);
        end
        checks++;
        if (td < 0 || tr !== td + 1) begin
            errors++; $display("FAIL single_lat: rsp=%0d done=%0d expected rsp=done+1", tr, td);
        end
        checks++;
        if (id !== 1 || g !== gcd_ref(16'd48, 16'd18) || e !== 1'b0) begin
            errors++; $display("FAIL single_rsp: id=%0d gcd=%0d err=%b expected 1 %0d 0", id, g, e, gcd_ref(16'd48, 16'd18));
        end
    endtask

    task automatic test_zero();
        int ta, ts, td, tr, id, nc; logic [W-1:0] da, db, g; logic e;
        logic [W-1:0] za [3];
        logic [W-1:0] zb [3];
        int zi [3];
        za[0] = 16'd0;  zb[0] = 16'd35; zi[0] = 2;
        za[1] = 16'd0;  zb[1] = 16'd0;  zi[1] = 2;
        za[2] = 16'd77; zb[2] = 16'd0;  zi[2] = 3;
        for (int j = 0; j < 3; j++) begin
            run_one(zi[j], za[j], zb[j], ta, ts, td, tr, da, db, id, g, e, nc);
            checks++;
            if (nc !== 0 || ts !== -1) begin
                errors++; $display("FAIL zero_bypass%0d: clr=%0d start_cycle=%0d expected no engine use", j, nc, ts);
            end
            checks++;
            if (ta < 0 || tr !== ta + 1) begin
                errors++; $display("FAIL zero_lat%0d: rsp=%0d accept=%0d expected accept+1", j, tr, ta);
            end
            checks++;
            if (id !== zi[j] || g !== (za[j] | zb[j]) || e !== 1'b0) begin
                errors++; $display("FAIL zero_rsp%0d: id=%0d gcd=%0d err=%b expected %0d %0d 0", j, id, g, e, zi[j], za[j] | zb[j]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] masks [3];
        masks[0] = 4'b1111; masks[1] = 4'b1001; masks[2] = 4'b0110;
        rst = 1'b1; tick(); rst = 1'b0; m_last = NREQ - 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = W'($urandom_range(1, 3000));
                op_b[i] = W'($urandom_range(1, 3000));
            end
            model_order(masks[r]);
            run_batch(masks[r], 1'b0);
            checks++;
            if (got_id.size() !== exp_q.size()) begin
                errors++; $display("FAIL rr_count%0d: got %0d responses expected %0d", r, got_id.size(), exp_q.size());
            end
            for (int j = 0; j < exp_q.size() && j < got_id.size(); j++) begin
                checks++;
                if (got_id[j] !== exp_q[j]) begin
                    errors++; $display("FAIL rr_order%0d.%0d: id=%0d expected %0d", r, j, got_id[j], exp_q[j]);
                end
                checks++;
                if (got_g[j] !== gcd_ref(op_a[exp_q[j]], op_b[exp_q[j]]) || got_e[j] !== 1'b0) begin
                    errors++; $display("FAIL rr_gcd%0d.%0d: gcd=%0d err=%b expected %0d 0", r, j, got_g[j], got_e[j], gcd_ref(op_a[exp_q[j]], op_b[exp_q[j]]));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [IDW-1:0] id0; logic [W-1:0] g0; logic e0; bit seen, stable, rdy_bad;
        rsp_ready = 1'b0;
        set_req(1, 16'd100, 16'd75);
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (s_rsp_valid) seen = 1;
        end
        id0 = s_rsp_id; g0 = s_rsp_gcd; e0 = s_rsp_err;
        checks++;
        if (!seen || id0 !== 2'd1 || g0 !== gcd_ref(16'd100, 16'd75) || e0 !== 1'b0) begin
            errors++; $display("FAIL bp_rsp: seen=%0d id=%0d gcd=%0d err=%b expected 1 %0d 0", seen, id0, g0, e0, gcd_ref(16'd100, 16'd75));
        end
        set_req(3, 16'd21, 16'd14);
        stable = 1; rdy_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!s_rsp_valid || s_rsp_id !== id0 || s_rsp_gcd !== g0 || s_rsp_err !== e0) stable = 0;
            if (s_req_ready !== '0) rdy_bad = 1;
        end
        checks++;
        if (!stable) begin
            errors++; $display("FAIL bp_stable: id=%0d gcd=%0d expected held %0d %0d", s_rsp_id, s_rsp_gcd, id0, g0);
        end
        rsp_ready = 1'b1;
        tick();
        if (s_req_ready !== '0) rdy_bad = 1;
        checks++;
        if (rdy_bad) begin
            errors++; $display("FAIL bp_noaccept: req_ready=%b during RESP expected 0", s_req_ready);
        end
        tick();
        checks++;
        if (s_req_ready !== 4'b1000 || s_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_next: req_ready=%b rsp_valid=%b expected 1000 0", s_req_ready, s_rsp_valid);
        end
        seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (s_rsp_valid) seen = 1;
        end
        checks++;
        if (!seen || s_rsp_id !== 2'd3 || s_rsp_gcd !== gcd_ref(16'd21, 16'd14)) begin
            errors++; $display("FAIL bp_second: seen=%0d id=%0d gcd=%0d expected 3 %0d", seen, s_rsp_id, s_rsp_gcd, gcd_ref(16'd21, 16'd14));
        end
        m_last = 3;
    endtask

    task automatic test_timeout();
        int ta, ts, td, tr, id, nc; logic [W-1:0] da, db, g; logic e;
        eng_hang = 1'b1;
        run_one(0, 16'd9, 16'd6, ta, ts, td, tr, da, db, id, g, e, nc);
        checks++;
        if (ts < 0 || tr !== ts + 2 + TIMEOUT) begin
            errors++; $display("FAIL tmo_lat: rsp=%0d start=%0d expected start+%0d", tr, ts, 2 + TIMEOUT);
        end
        checks++;
        if (id !== 0 || g !== '0 || e !== 1'b1) begin
            errors++; $display("FAIL tmo_rsp: id=%0d gcd=%0d err=%b expected 0 0 1", id, g, e);
        end
        eng_hang = 1'b0;
        run_one(2, 16'd42, 16'd56, ta, ts, td, tr, da, db, id, g, e, nc);
        checks++;
        if (id !== 2 || g !== gcd_ref(16'd42, 16'd56) || e !== 1'b0) begin
            errors++; $display("FAIL tmo_after: id=%0d gcd=%0d err=%b expected 2 %0d 0", id, g, e, gcd_ref(16'd42, 16'd56));
        end
    endtask

    task automatic test_reset_mid_run();
        int ta, ts, td, tr, id, nc, touched; logic [W-1:0] da, db, g; logic e; bit seen;
        eng_hang = 1'b1;
        set_req(1, 16'd30, 16'd12);
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            tick();
            if (s_eng_start) seen = 1;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; m_last = NREQ - 1;
        tick();
        checks++;
        if (!seen || s_busy !== 1'b0 || s_rsp_valid !== 1'b0 || s_req_ready !== '0 ||
            s_eng_clr !== 1'b0 || s_eng_start !== 1'b0 || s_eng_din !== '0 ||
            s_rsp_id !== '0 || s_rsp_gcd !== '0 || s_rsp_err !== 1'b0) begin
            errors++; $display("FAIL rst_run: started=%0d busy=%b rsp_valid=%b clr=%b start=%b din=%0d gcd=%0d expected all 0",
                               seen, s_busy, s_rsp_valid, s_eng_clr, s_eng_start, s_eng_din, s_rsp_gcd);
        end
        touched = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (s_rsp_valid || s_eng_clr || s_eng_start || s_busy) touched++;
        end
        checks++;
        if (touched !== 0) begin
            errors++; $display("FAIL rst_quiet: %0d active cycles after reset expected 0", touched);
        end
        eng_hang = 1'b0;
        run_one(0, 16'd81, 16'd27, ta, ts, td, tr, da, db, id, g, e, nc);
        checks++;
        if (id !== 0 || g !== gcd_ref(16'd81, 16'd27) || e !== 1'b0 || ts !== ta + 2) begin
            errors++; $display("FAIL rst_after: id=%0d gcd=%0d err=%b start=%0d expected 0 %0d 0 %0d", id, g, e, ts, gcd_ref(16'd81, 16'd27), ta + 2);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        for (int r = 0; r < 10; r++) begin
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 60000));
                op_b[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 60000));
            end
            model_order(mask);
            run_batch(mask, 1'b1);
            checks++;
            if (got_id.size() !== exp_q.size()) begin
                errors++; $display("FAIL rnd_count%0d: got %0d responses expected %0d", r, got_id.size(), exp_q.size());
            end
            for (int j = 0; j < exp_q.size() && j < got_id.size(); j++) begin
                checks++;
                if (got_id[j] !== exp_q[j] || got_g[j] !== gcd_ref(op_a[exp_q[j]], op_b[exp_q[j]]) || got_e[j] !== 1'b0) begin
                    errors++; $display("FAIL rnd%0d.%0d: id=%0d gcd=%0d err=%b expected %0d %0d 0", r, j, got_id[j], got_g[j], got_e[j],
                                       exp_q[j], gcd_ref(op_a[exp_q[j]], op_b[exp_q[j]]));
                end
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (ready_bad !== 0) begin
            errors++; $display("FAIL ready_rules: %0d cycles with req_ready while busy or not one-hot expected 0", ready_bad);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_zero();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_run();
        test_random();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gcd_job_arbiter
`default_nettype wire
